// File: rtl/dpm_port_arbiter.sv
// dpm_port_arbiter: shares one memory port among NREQ requesters, one access at a time.
// Optional macro DPM_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins) instead of round robin.
module dpm_port_arbiter #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 3,
    parameter int NREQ  = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NREQ-1:0]         i_req,
    input  logic [NREQ-1:0]         i_we,
    input  logic [NREQ*ADDR-1:0]    i_addr,
    input  logic [NREQ*WIDTH-1:0]   i_din,
    output logic [NREQ-1:0]         o_gnt,
    output logic [NREQ-1:0]         o_rvalid,
    output logic [WIDTH-1:0]        o_rdata,
    output logic                    o_busy,
    output logic                    o_mem_en,
    output logic                    o_mem_we,
    output logic [ADDR-1:0]         o_mem_addr,
    output logic [WIDTH-1:0]        o_mem_din,
    input  logic [WIDTH-1:0]        i_mem_dout
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RDCAP} state_t;

    state_t        state;
    logic [IW-1:0] win_idx;
    logic          win_we;
    logic [IW-1:0] winner;
    logic          found;

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        return NREQ'(1) << idx;
    endfunction

`ifdef DPM_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && i_req[k]) begin
                winner = IW'(k);
                found  = 1'b1;
            end
        end
    end
`else
    logic [IW-1:0] ptr;
    logic [IW-1:0] cand;

    // Search starts just after the last granted requester so every requester gets a turn.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (!found && i_req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end
`endif

    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            win_idx    <= '0;
            win_we     <= 1'b0;
            o_gnt      <= '0;
            o_rvalid   <= '0;
            o_rdata    <= '0;
            o_mem_en   <= 1'b0;
            o_mem_we   <= 1'b0;
            o_mem_addr <= '0;
            o_mem_din  <= '0;
`ifndef DPM_ARB_FIXED_PRIO_EN
            ptr        <= IW'(NREQ - 1);
`endif
        end else begin
            case (state)
                IDLE: begin
                    o_rvalid <= '0;
                    o_gnt    <= '0;
                    o_mem_en <= 1'b0;
                    o_mem_we <= 1'b0;
                    if (found) begin
                        o_mem_en   <= 1'b1;
                        o_mem_we   <= i_we[winner];
                        o_mem_addr <= i_addr[int'(winner)*ADDR +: ADDR];
                        o_mem_din  <= i_din[int'(winner)*WIDTH +: WIDTH];
                        o_gnt      <= onehot(winner);
                        win_idx    <= winner;
                        win_we     <= i_we[winner];
`ifndef DPM_ARB_FIXED_PRIO_EN
                        ptr        <= winner;
`endif
                        state      <= ISSUE;
                    end
                end
                // The memory performs the access on this edge; address/data stay put.
                ISSUE: begin
                    o_gnt    <= '0;
                    o_mem_en <= 1'b0;
                    o_mem_we <= 1'b0;
                    state    <= win_we ? IDLE : RDCAP;
                end
                RDCAP: begin
                    o_rdata  <= i_mem_dout;
                    o_rvalid <= onehot(win_idx);
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dpm_port_arbiter.sv
// Scoreboard bench for dpm_port_arbiter (default round-robin build) with a small synchronous memory model.
module tb_dpm_port_arbiter;

    localparam int WIDTH = 8;
    localparam int ADDR  = 3;
    localparam int NREQ  = 4;

    typedef struct {
        int          idx;
        bit          we;
        logic [2:0]  addr;
        logic [7:0]  data;
    } exp_t;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_v;
    logic [NREQ-1:0]       we_v;
    logic [NREQ*ADDR-1:0]  addr_v;
    logic [NREQ*WIDTH-1:0] din_v;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       rvalid;
    logic [WIDTH-1:0]      rdata;
    logic                  busy;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR-1:0]       mem_addr;
    logic [WIDTH-1:0]      mem_din;
    logic [WIDTH-1:0]      mem_dout;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int gnt_count = 0;
    int rvalid_count = 0;
    int last_rd_gnt_cyc = 0;
    int gnt_cyc_log[$];
    exp_t exp_gnt[$];
    exp_t exp_rd[$];

    logic [7:0] mem [8];
    logic       mem_loaded = 1'b0;

    dpm_port_arbiter #(.WIDTH(WIDTH), .ADDR(ADDR), .NREQ(NREQ)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req      (req_v),
        .i_we       (we_v),
        .i_addr     (addr_v),
        .i_din      (din_v),
        .o_gnt      (gnt),
        .o_rvalid   (rvalid),
        .o_rdata    (rdata),
        .o_busy     (busy),
        .o_mem_en   (mem_en),
        .o_mem_we   (mem_we),
        .o_mem_addr (mem_addr),
        .o_mem_din  (mem_din),
        .i_mem_dout (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memory: preloaded with 0x50+addr on the first edge (during reset).
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int a = 0; a < 8; a++) mem[a] <= 8'h50 + 8'(a);
            mem_loaded <= 1'b1;
            mem_dout   <= 8'h00;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_din;
            else        mem_dout      <= mem[mem_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] need);
        checks++;
        if (obs !== need) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, need 0x%0h (cycle %0d)", tag, obs, need, cyc);
        end
    endtask

    // Monitor pops the scoreboard whenever the DUT pulses a grant or read-valid.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (gnt != '0) begin
                gnt_count++;
                gnt_cyc_log.push_back(cyc);
                if (exp_gnt.size() == 0) begin
                    checkOutput("gnt_unexpected", 32'(gnt), 32'h0);
                end else begin
                    e = exp_gnt.pop_front();
                    checkOutput("gnt", 32'(gnt), 32'(1) << e.idx);
                    checkOutput("mem_en", 32'(mem_en), 32'h1);
                    checkOutput("busy", 32'(busy), 32'h1);
                    checkOutput("mem_we", 32'(mem_we), 32'(e.we));
                    checkOutput("mem_addr", 32'(mem_addr), 32'(e.addr));
                    if (e.we) checkOutput("mem_din", 32'(mem_din), 32'(e.data));
                end
                if (!mem_we) last_rd_gnt_cyc = cyc;
            end else begin
                checkOutput("mem_en_idle", 32'(mem_en), 32'h0);
            end
            if (rvalid != '0) begin
                rvalid_count++;
                if (exp_rd.size() == 0) begin
                    checkOutput("rvalid_unexpected", 32'(rvalid), 32'h0);
                end else begin
                    e = exp_rd.pop_front();
                    checkOutput("rvalid", 32'(rvalid), 32'(1) << e.idx);
                    checkOutput("rdata", 32'(rdata), 32'(e.data));
                    checkOutput("read_latency", 32'(cyc - last_rd_gnt_cyc), 32'd2);
                end
            end
        end
    end

    task automatic applyStimulus(input int r, input bit w, input logic [2:0] a, input logic [7:0] d);
        we_v[r]               = w;
        addr_v[r*ADDR +: ADDR]  = a;
        din_v[r*WIDTH +: WIDTH] = d;
        req_v[r]              = 1'b1;
    endtask

    task automatic dropReq(input int r);
        req_v[r] = 1'b0;
    endtask

    task automatic pushGnt(input int r, input bit w, input logic [2:0] a, input logic [7:0] d);
        exp_t e;
        e.idx = r; e.we = w; e.addr = a; e.data = d;
        exp_gnt.push_back(e);
    endtask

    task automatic pushRd(input int r, input logic [7:0] d);
        exp_t e;
        e.idx = r; e.we = 1'b0; e.addr = '0; e.data = d;
        exp_rd.push_back(e);
    endtask

    task automatic waitGrants(input int target);
        for (int c = 0; c < 200 && gnt_count < target; c++) begin
            @(posedge clk);
            #1;
        end
        if (gnt_count < target) checkOutput("timeout_gnt", 32'(gnt_count), 32'(target));
    endtask

    task automatic waitIdle();
        for (int c = 0; c < 200 && (exp_gnt.size() != 0 || exp_rd.size() != 0 || busy); c++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("pending_at_idle", 32'(exp_gnt.size() + exp_rd.size()), 32'h0);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_gnt"}, 32'(gnt), 32'h0);
        checkOutput({tag, "_rvalid"}, 32'(rvalid), 32'h0);
        checkOutput({tag, "_rdata"}, 32'(rdata), 32'h0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
        checkOutput({tag, "_mem_en_we"}, {30'h0, mem_en, mem_we}, 32'h0);
        checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
        checkOutput({tag, "_mem_din"}, 32'(mem_din), 32'h0);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int tgt;
        int base;
        int saved;
        rst = 1'b0; req_v = '0; we_v = '0; addr_v = '0; din_v = '0;
        #2 rst = 1'b1;
        #1 checkReset("por");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Round robin: all four read continuously, expect 0,1,2,3,0 every 3 cycles.
        base = gnt_cyc_log.size();
        for (int r = 0; r < NREQ; r++) pushGnt(r, 1'b0, 3'(r), 8'h00);
        pushGnt(0, 1'b0, 3'd0, 8'h00);
        for (int r = 0; r < NREQ; r++) pushRd(r, 8'h50 + 8'(r));
        pushRd(0, 8'h50);
        tgt = gnt_count + 5;
        for (int r = 0; r < NREQ; r++) applyStimulus(r, 1'b0, 3'(r), 8'h00);
        waitGrants(tgt);
        req_v = '0;
        waitIdle();
        for (int i = 1; i < 5; i++)
            checkOutput("rr_interval", 32'(gnt_cyc_log[base+i] - gnt_cyc_log[base+i-1]), 32'd3);

        // Contention: req1 writes 0x3C to addr 5, req2 reads addr 5.
        base = gnt_cyc_log.size();
        pushGnt(1, 1'b1, 3'd5, 8'h3C);
        pushGnt(2, 1'b0, 3'd5, 8'h00);
        pushRd(2, 8'h3C);
        tgt = gnt_count;
        applyStimulus(1, 1'b1, 3'd5, 8'h3C);
        applyStimulus(2, 1'b0, 3'd5, 8'h00);
        waitGrants(tgt + 1);
        dropReq(1);
        waitGrants(tgt + 2);
        dropReq(2);
        waitIdle();
        checkOutput("write_interval", 32'(gnt_cyc_log[base+1] - gnt_cyc_log[base]), 32'd2);

        // Single requester write then read-back.
        pushGnt(0, 1'b1, 3'd3, 8'hA5);
        tgt = gnt_count + 1;
        applyStimulus(0, 1'b1, 3'd3, 8'hA5);
        waitGrants(tgt);
        dropReq(0);
        waitIdle();
        pushGnt(0, 1'b0, 3'd3, 8'h00);
        pushRd(0, 8'hA5);
        tgt = gnt_count + 1;
        applyStimulus(0, 1'b0, 3'd3, 8'h00);
        waitGrants(tgt);
        dropReq(0);
        waitIdle();

        // Reset while the read sits in RDCAP: no read-valid, pointer restored.
        pushGnt(1, 1'b0, 3'd2, 8'h77);
        tgt = gnt_count + 1;
        applyStimulus(1, 1'b0, 3'd2, 8'h77);
        waitGrants(tgt);
        dropReq(1);
        #2 rst = 1'b1;
        exp_gnt.delete();
        exp_rd.delete();
        #1 checkReset("rst_mid_read");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        saved = rvalid_count;
        repeat (6) @(posedge clk);
        #1 checkOutput("no_rvalid_after_reset", 32'(rvalid_count), 32'(saved));

        // Only req0 and req3 active: alternate 0,3,0,3 starting at 0 after reset.
        pushGnt(0, 1'b0, 3'd6, 8'h00);
        pushGnt(3, 1'b0, 3'd7, 8'h00);
        pushGnt(0, 1'b0, 3'd6, 8'h00);
        pushGnt(3, 1'b0, 3'd7, 8'h00);
        pushRd(0, 8'h56);
        pushRd(3, 8'h57);
        pushRd(0, 8'h56);
        pushRd(3, 8'h57);
        tgt = gnt_count + 4;
        applyStimulus(0, 1'b0, 3'd6, 8'h00);
        applyStimulus(3, 1'b0, 3'd7, 8'h00);
        waitGrants(tgt);
        req_v = '0;
        waitIdle();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
